// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge: CPU stores/loads in the addr[7]=1 window drive a TX and an RX FIFO.
// Optional interrupt output and CONTROL enable bits are built when IO_BRIDGE_IRQ_EN is defined.
module io_port_bridge #(
  parameter int FIFO_AW    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef IO_BRIDGE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = FIFO_AW + 1;

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [CW-1:0]      cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_RXDATA  = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CONTROL = 2'd3
  } reg_sel_t;

  logic [31:0] tx_mem [FIFO_DEPTH];
  logic [31:0] rx_mem [FIFO_DEPTH];

  ptr_t tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  cnt_t tx_cnt, rx_cnt;
  logic tx_ovf, rx_udf;

  logic     io_sel, cpu_store, cpu_load;
  reg_sel_t reg_sel;
  logic     tx_empty, tx_full, rx_empty, rx_full;
  logic     tx_push_req, tx_pop, tx_push, tx_ovf_set;
  logic     rx_pop_req, rx_pop, rx_push, rx_udf_set;
  logic     status_wr, ctrl_wr, tx_flush, rx_flush;
  logic     ovf_clr, udf_clr;
  logic [31:0] status_word, rx_head;

  // A simultaneous we/re is treated purely as a store.
  assign io_sel    = addr[7];
  assign reg_sel   = reg_sel_t'(addr[3:2]);
  assign cpu_store = io_sel & we;
  assign cpu_load  = io_sel & re & ~we;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);

  assign status_wr = cpu_store & (reg_sel == REG_STATUS);
  assign ctrl_wr   = cpu_store & (reg_sel == REG_CONTROL);
  assign tx_flush  = ctrl_wr & wdata[0];
  assign rx_flush  = ctrl_wr & wdata[1];

  // A consumer pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign tx_push_req = cpu_store & (reg_sel == REG_TXDATA);
  assign tx_pop      = ~tx_empty & tx_ready & ~tx_flush;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;
  assign tx_ovf_set  = tx_push_req & tx_full & ~(~tx_empty & tx_ready);

  assign rx_pop_req = cpu_load & (reg_sel == REG_RXDATA);
  assign rx_pop     = rx_pop_req & ~rx_empty & ~rx_flush;
  assign rx_push    = rx_valid & ~rx_full & ~rx_flush;
  assign rx_udf_set = rx_pop_req & rx_empty;

  assign ovf_clr = status_wr & wdata[4];
  assign udf_clr = status_wr & wdata[5];

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 32'h0 : tx_mem[tx_rd_ptr];
  assign rx_ready = ~rx_full;
  assign rx_head  = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + cnt_t'(1);
        2'b01:   tx_cnt <= tx_cnt - cnt_t'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + cnt_t'(1);
        2'b01:   rx_cnt <= rx_cnt - cnt_t'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky flags: a new set event beats a W1C in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= tx_ovf_set | (tx_ovf & ~ovf_clr);
      rx_udf <= rx_udf_set | (rx_udf & ~udf_clr);
    end
  end

  always_comb begin
    status_word            = '0;
    status_word[16 +: CW]  = rx_cnt;
    status_word[8 +: CW]   = tx_cnt;
    status_word[5:0]       = {rx_udf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};
  end

`ifdef IO_BRIDGE_IRQ_EN
  logic rx_ie, tx_ie;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= wdata[2];
        tx_ie <= wdata[3];
      end
      irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | tx_ovf | rx_udf;
    end
  end
`endif

  always_comb begin
    rdata = 32'h0;
    if (cpu_load) begin
      case (reg_sel)
        REG_RXDATA:  rdata = rx_head;
        REG_STATUS:  rdata = status_word;
`ifdef IO_BRIDGE_IRQ_EN
        REG_CONTROL: rdata = {28'h0, tx_ie, rx_ie, 2'b00};
`endif
        default:     rdata = 32'h0;
      endcase
    end
  end

  // Undecoded address and data bits collected so they are visibly intentional.
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], addr[6:4], addr[1:0], wdata[31:6], wdata[3:2]};

endmodule
